icache_snoop_invalidate: RTL and testbench

- Consumer stage of the dcache-to-icache address FIFO. Pops the line addresses that dcache writes have produced and looks each one up in the L1 icache tag array. Any valid way whose tag matches has its valid bit cleared.
- Keeps the icache coherent with self-modifying code.
- Pulses snoop_hit so the prefetch/decode path can discard stale bytes.
- Arbitrates with icache fills through a busy/hold handshake.

---
 rtl/icache_snoop_invalidate_if.sv | 57 +++++
 rtl/icache_snoop_invalidate.sv | 92 +++++++++
 tb/tb_icache_snoop_invalidate.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_snoop_invalidate_if.sv
// Bundle between the dcache->icache snoop stage, its address FIFO, the icache
// tag array and the icache fill arbiter.
interface icache_snoop_invalidate_if #(
  parameter int unsigned INDEX_WIDTH = 7
);
  localparam int unsigned TAG_WIDTH = 28 - INDEX_WIDTH;
  localparam int unsigned SET_WIDTH = 4 * (TAG_WIDTH + 1);

  logic                   accept_do;
  logic [31:0]            accept_address;
  logic                   accept_empty;
  logic                   icache_busy;
  logic                   icache_flush;
  logic                   snoop_busy;
  logic                   tag_rd_do;
  logic [INDEX_WIDTH-1:0] tag_rd_index;
  logic [SET_WIDTH-1:0]   tag_rd_data;
  logic                   tag_wr_do;
  logic [INDEX_WIDTH-1:0] tag_wr_index;
  logic [SET_WIDTH-1:0]   tag_wr_data;
  logic                   snoop_hit;
  logic [31:0]            snoop_hit_address;

  modport master (
    output accept_do,
    input  accept_address,
    input  accept_empty,
    input  icache_busy,
    input  icache_flush,
    output snoop_busy,
    output tag_rd_do,
    output tag_rd_index,
    input  tag_rd_data,
    output tag_wr_do,
    output tag_wr_index,
    output tag_wr_data,
    output snoop_hit,
    output snoop_hit_address
  );

  modport slave (
    input  accept_do,
    output accept_address,
    output accept_empty,
    output icache_busy,
    output icache_flush,
    input  snoop_busy,
    input  tag_rd_do,
    input  tag_rd_index,
    output tag_rd_data,
    input  tag_wr_do,
    input  tag_wr_index,
    input  tag_wr_data,
    input  snoop_hit,
    input  snoop_hit_address
  );
endinterface

// File: rtl/icache_snoop_invalidate.sv
// Pops dcache-written line addresses and clears the valid bit of every icache way
// whose tag matches, so self-modifying code never executes stale icache lines.
module icache_snoop_invalidate #(
  parameter int unsigned INDEX_WIDTH = 7
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  icache_snoop_invalidate_if.master bus
);
  localparam int unsigned TAG_WIDTH = 28 - INDEX_WIDTH;
  localparam int unsigned WAY_WIDTH = TAG_WIDTH + 1;
  localparam int unsigned NUM_WAYS  = 4;
  localparam int unsigned SET_WIDTH = NUM_WAYS * WAY_WIDTH;

  typedef enum logic {StIdle, StCheck} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [31:0]           r_addr;
  logic [31:0]           r_hit_addr;
  logic                  w_start;
  logic                  w_hit;
  logic [NUM_WAYS-1:0]   w_match;
  logic [SET_WIDTH-1:0]  w_wr_data;

  // Read data arrives in CHECK; matching ways lose only their valid bit.
  always_comb begin
    w_wr_data = bus.tag_rd_data;
    w_match   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_match[w] = bus.tag_rd_data[w*WAY_WIDTH + TAG_WIDTH] &&
                   (bus.tag_rd_data[w*WAY_WIDTH +: TAG_WIDTH] == r_addr[31:INDEX_WIDTH+4]);
      if (w_match[w]) begin
        w_wr_data[w*WAY_WIDTH + TAG_WIDTH] = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_start        = 1'b0;
    w_hit          = 1'b0;
    bus.accept_do  = 1'b0;
    bus.tag_rd_do  = 1'b0;
    bus.tag_wr_do  = 1'b0;
    bus.snoop_busy = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!bus.accept_empty && bus.icache_flush) begin
          // A full flush is in progress, so queued snoops are simply drained.
          bus.accept_do = 1'b1;
        end else if (!bus.accept_empty && !bus.icache_busy) begin
          bus.accept_do  = 1'b1;
          bus.tag_rd_do  = 1'b1;
          bus.snoop_busy = 1'b1;
          w_start        = 1'b1;
          w_state_d      = StCheck;
        end
      end
      StCheck: begin
        bus.snoop_busy = 1'b1;
        w_hit          = |w_match;
        bus.tag_wr_do  = w_hit;
        w_state_d      = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.tag_rd_index = bus.accept_address[INDEX_WIDTH+3:4];
  assign bus.tag_wr_index = r_addr[INDEX_WIDTH+3:4];
  assign bus.tag_wr_data  = w_wr_data;
  assign bus.snoop_hit    = w_hit;
  // Hit address shows the new line in the hit cycle, then holds it until the next hit.
  assign bus.snoop_hit_address = w_hit ? r_addr : r_hit_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_hit_addr <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_addr <= bus.accept_address;
      end
      if (w_hit) begin
        r_hit_addr <= r_addr;
      end
    end
  end
endmodule

// File: tb/tb_icache_snoop_invalidate.sv
// Bench: models the address FIFO and tag RAM, and predicts the snoop outputs from
// an entry-level view of the cache contents.
module tb_icache_snoop_invalidate;
  localparam int unsigned IW    = 7;
  localparam int unsigned TW    = 28 - IW;
  localparam int unsigned WW    = TW + 1;
  localparam int unsigned DW    = 4 * WW;
  localparam int unsigned NSETS = 1 << IW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_snoop_invalidate_if #(.INDEX_WIDTH(IW)) bus ();

  icache_snoop_invalidate #(.INDEX_WIDTH(IW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0]   q[$];
  logic [DW-1:0] ram [NSETS];
  bit            g_v [NSETS][4];
  logic [TW-1:0] g_t [NSETS][4];

  // Model: is an entry between its tag read and its write-back?
  bit          m_inflight;
  logic [31:0] m_addr;
  logic [31:0] m_last;

  bit          e_rd;
  logic [3:0]  e_mask;
  int          e_idx;
  logic [31:0] e_head;

  bit            d_acc, d_rd, d_wr;
  logic [IW-1:0] d_rd_idx, d_wr_idx;
  logic [DW-1:0] d_wr_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] golden_set(input int s);
    logic [DW-1:0] r;
    r = '0;
    for (int w = 0; w < 4; w++) r[w*WW +: WW] = {g_v[s][w], g_t[s][w]};
    return r;
  endfunction

  task automatic set_way(input int s, input int w, input bit v, input logic [TW-1:0] t);
    g_v[s][w] = v;
    g_t[s][w] = t;
    ram[s][w*WW +: WW] = {v, t};
  endtask

  task automatic drive_fifo();
    bus.accept_empty   = (q.size() == 0);
    bus.accept_address = (q.size() == 0) ? 32'h0 : q[0];
  endtask

  task automatic reset_model();
    m_inflight = 1'b0;
    m_addr     = '0;
    m_last     = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) begin
      a = $urandom & 32'hFFFF_FFF0;
    end else begin
      a = '0;
      a[31:IW+4] = TW'($urandom_range(0, 3));
      a[IW+3:4]  = IW'($urandom_range(0, 3));
    end
    return a;
  endfunction

  task automatic refill();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 4; w++)
        set_way(s, w, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)));
  endtask

  // Per-cycle compare at the falling edge against the model's expectations.
  task automatic sample();
    bit            empty, e_acc, e_sb, e_wr;
    logic [31:0]   head, e_ha;
    logic [TW-1:0] tag;
    logic [DW-1:0] wd;
    @(negedge clk);
    empty  = (q.size() == 0);
    head   = empty ? 32'h0 : q[0];
    e_acc  = !empty && !m_inflight && (bus.icache_flush || !bus.icache_busy);
    e_rd   = !empty && !m_inflight && !bus.icache_flush && !bus.icache_busy;
    e_sb   = m_inflight || e_rd;
    e_mask = '0;
    e_idx  = 0;
    wd     = '0;
    if (m_inflight) begin
      e_idx = int'(m_addr[IW+3:4]);
      tag   = m_addr[31:IW+4];
      wd    = golden_set(e_idx);
      for (int w = 0; w < 4; w++) begin
        if (g_v[e_idx][w] && g_t[e_idx][w] == tag) begin
          e_mask[w] = 1'b1;
          wd[w*WW + TW] = 1'b0;
        end
      end
    end
    if (!rst_n) begin
      e_acc = 0; e_rd = 0; e_sb = 0; e_mask = '0;
    end
    e_wr   = (e_mask != 0);
    e_ha   = e_wr ? m_addr : m_last;
    e_head = head;
    chk("accept_do", bus.accept_do, e_acc);
    chk("tag_rd_do", bus.tag_rd_do, e_rd);
    chk("snoop_busy", bus.snoop_busy, e_sb);
    chk("tag_wr_do", bus.tag_wr_do, e_wr);
    chk("snoop_hit", bus.snoop_hit, e_wr);
    chk("snoop_hit_address", bus.snoop_hit_address, e_ha);
    if (e_rd) chk("tag_rd_index", bus.tag_rd_index, head[IW+3:4]);
    if (e_wr) begin
      chk("tag_wr_index", bus.tag_wr_index, m_addr[IW+3:4]);
      chk("tag_wr_data", bus.tag_wr_data, wd);
    end
    d_acc     = bus.accept_do;
    d_rd      = bus.tag_rd_do;
    d_wr      = bus.tag_wr_do;
    d_rd_idx  = bus.tag_rd_index;
    d_wr_idx  = bus.tag_wr_index;
    d_wr_data = bus.tag_wr_data;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (d_acc && q.size() > 0) q.delete(0);
      if (d_rd) bus.tag_rd_data = ram[d_rd_idx];
      if (d_wr) ram[d_wr_idx] = d_wr_data;
      if (m_inflight) begin
        for (int w = 0; w < 4; w++) if (e_mask[w]) g_v[e_idx][w] = 1'b0;
        if (e_mask != 0) m_last = m_addr;
        m_inflight = 1'b0;
      end else if (e_rd) begin
        m_inflight = 1'b1;
        m_addr     = e_head;
      end
    end
    drive_fifo();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] acc7, sb7;
    logic [5:0] acc6;
    int         cnt, rd_cnt, wr_cnt, bad;

    bus.icache_busy  = 1'b0;
    bus.icache_flush = 1'b0;
    bus.tag_rd_data  = '0;
    for (int s = 0; s < NSETS; s++) for (int w = 0; w < 4; w++) set_way(s, w, 1'b0, '0);
    reset_model();
    drive_fifo();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_accept_do", bus.accept_do, 1'b0);
    chk("reset_snoop_busy", bus.snoop_busy, 1'b0);
    chk("reset_hit_address", bus.snoop_hit_address, 32'h0);
    rst_n = 1'b1;

    // Single hit: 0x0001_2340 -> index 0x34, tag 0x24, way 2 valid
    set_way(7'h34, 2, 1'b1, TW'(24'h24));
    q.push_back(32'h0001_2340);
    drive_fifo();
    sample();
    chk("hit_c0_accept", bus.accept_do, 1'b1);
    chk("hit_c0_rd_index", bus.tag_rd_index, 7'h34);
    adv();
    sample();
    chk("hit_c1_wr_do", bus.tag_wr_do, 1'b1);
    chk("hit_c1_wr_data", bus.tag_wr_data, {22'h0, 22'h00_0024, 22'h0, 22'h0});
    chk("hit_c1_snoop_hit", bus.snoop_hit, 1'b1);
    chk("hit_c1_hit_address", bus.snoop_hit_address, 32'h0001_2340);
    adv();

    // Miss: way 2 now holds a different tag
    set_way(7'h34, 2, 1'b1, TW'(24'h25));
    q.push_back(32'h0001_2340);
    drive_fifo();
    sample();
    adv();
    sample();
    chk("miss_wr_do", bus.tag_wr_do, 1'b0);
    chk("miss_snoop_hit", bus.snoop_hit, 1'b0);
    chk("miss_hit_address_held", bus.snoop_hit_address, 32'h0001_2340);
    adv();

    // Back-to-back: three entries
    refill();
    for (int i = 0; i < 3; i++) q.push_back(rand_addr());
    drive_fifo();
    for (int i = 0; i < 7; i++) begin
      sample();
      acc7[i] = bus.accept_do;
      sb7[i]  = bus.snoop_busy;
      adv();
    end
    chk("b2b_accept_pattern", acc7, 7'b0010101);
    chk("b2b_busy_pattern", sb7, 7'b0111111);

    // Arbitration: icache_busy blocks the start
    bus.icache_busy = 1'b1;
    q.push_back(rand_addr());
    drive_fifo();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      cnt += int'(bus.accept_do) + int'(bus.tag_rd_do);
      adv();
    end
    chk("arb_blocked_strobes", cnt, 0);
    bus.icache_busy = 1'b0;
    sample();
    chk("arb_pop_on_release", bus.accept_do, 1'b1);
    adv();
    sample();
    adv();

    // Flush drain: four entries, one per cycle, no tag traffic
    bus.icache_flush = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(rand_addr());
    drive_fifo();
    rd_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sample();
      acc6[i] = bus.accept_do;
      rd_cnt += int'(bus.tag_rd_do);
      wr_cnt += int'(bus.tag_wr_do);
      adv();
    end
    bus.icache_flush = 1'b0;
    chk("flush_accept_pattern", acc6, 6'b001111);
    chk("flush_rd_count", rd_cnt, 0);
    chk("flush_wr_count", wr_cnt, 0);

    // Reset in the middle of a CHECK cycle
    set_way(7'h34, 1, 1'b1, TW'(24'h24));
    q.push_back(32'h0001_2340);
    drive_fifo();
    sample();
    adv();
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("rst_mid_strobes",
        {bus.accept_do, bus.tag_rd_do, bus.tag_wr_do, bus.snoop_hit, bus.snoop_busy}, 5'b0);
    chk("rst_mid_hit_address", bus.snoop_hit_address, 32'h0);
    sample();
    adv();
    rst_n = 1'b1;
    wr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      wr_cnt += int'(bus.tag_wr_do);
      adv();
    end
    chk("rst_no_write_after", wr_cnt, 0);
    set_way(7'h34, 1, 1'b0, '0);

    // Randomized traffic
    refill();
    for (int i = 0; i < 1500; i++) begin
      sample();
      adv();
      if (q.size() < 6 && $urandom_range(0, 2) == 0) q.push_back(rand_addr());
      bus.icache_busy  = ($urandom_range(0, 3) == 0);
      bus.icache_flush = ($urandom_range(0, 11) == 0);
      if (!m_inflight && $urandom_range(0, 39) == 0) refill();
      drive_fifo();
    end
    bus.icache_flush = 1'b0;
    bus.icache_busy  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample();
      adv();
    end

    bad = 0;
    for (int s = 0; s < NSETS; s++) if (ram[s] !== golden_set(s)) bad++;
    chk("tag_array_vs_model", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
